// File: rtl/instr_sequencer_if.sv
// Shared command/addressing-mode constants and the sequencer port bundle.
// The sequencer uses the master modport; the decoder/bus side uses slave.
package seq_pkg;
  localparam logic [5:0] CMD_NOP = 6'd0;
  localparam logic [5:0] CMD_LDA = 6'd1;
  localparam logic [5:0] CMD_LDX = 6'd2;
  localparam logic [5:0] CMD_LDY = 6'd3;
  localparam logic [5:0] CMD_STA = 6'd4;
  localparam logic [5:0] CMD_STX = 6'd5;
  localparam logic [5:0] CMD_STY = 6'd6;
  localparam logic [5:0] CMD_ADC = 6'd7;
  localparam logic [5:0] CMD_SBC = 6'd8;
  localparam logic [5:0] CMD_AND = 6'd9;
  localparam logic [5:0] CMD_ORA = 6'd10;
  localparam logic [5:0] CMD_EOR = 6'd11;
  localparam logic [5:0] CMD_CMP = 6'd12;
  localparam logic [5:0] CMD_BIT = 6'd13;
  localparam logic [5:0] CMD_ASL = 6'd14;
  localparam logic [5:0] CMD_LSR = 6'd15;
  localparam logic [5:0] CMD_ROL = 6'd16;
  localparam logic [5:0] CMD_ROR = 6'd17;
  localparam logic [5:0] CMD_INC = 6'd18;
  localparam logic [5:0] CMD_DEC = 6'd19;
  localparam logic [5:0] CMD_INX = 6'd20;
  localparam logic [5:0] CMD_DEX = 6'd21;
  localparam logic [5:0] CMD_PHA = 6'd22;
  localparam logic [5:0] CMD_PHP = 6'd23;
  localparam logic [5:0] CMD_PLA = 6'd24;
  localparam logic [5:0] CMD_PLP = 6'd25;
  localparam logic [5:0] CMD_JMP = 6'd26;
  localparam logic [5:0] CMD_JSR = 6'd27;
  localparam logic [5:0] CMD_RTS = 6'd28;
  localparam logic [5:0] CMD_RTI = 6'd29;
  localparam logic [5:0] CMD_BRK = 6'd30;
  localparam logic [5:0] CMD_BNE = 6'd31;
  localparam logic [5:0] CMD_BEQ = 6'd32;
  localparam logic [5:0] CMD_BCC = 6'd33;
  localparam logic [5:0] CMD_BCS = 6'd34;

  localparam logic [3:0] AM_IMPL = 4'd0;
  localparam logic [3:0] AM_ACC  = 4'd1;
  localparam logic [3:0] AM_IMM  = 4'd2;
  localparam logic [3:0] AM_ZPG  = 4'd3;
  localparam logic [3:0] AM_ZPGX = 4'd4;
  localparam logic [3:0] AM_ZPGY = 4'd5;
  localparam logic [3:0] AM_ABS  = 4'd6;
  localparam logic [3:0] AM_ABSX = 4'd7;
  localparam logic [3:0] AM_ABSY = 4'd8;
  localparam logic [3:0] AM_XIND = 4'd9;
  localparam logic [3:0] AM_INDY = 4'd10;
  localparam logic [3:0] AM_REL  = 4'd11;
endpackage

interface instr_sequencer_if #(
  parameter int T_W = 3
);
  logic           ready;
  logic [7:0]     data_in;
  logic [5:0]     cmd;
  logic [3:0]     address_mode;
  logic           page_cross;
  logic           branch_taken;
  logic [7:0]     ir;
  logic [T_W-1:0] t_state;
  logic           sync;
  logic           instr_done;

  modport master (
    input  ready, data_in, cmd, address_mode,
    input  page_cross, branch_taken,
    output ir, t_state, sync, instr_done
  );

  modport slave (
    output ready, data_in, cmd, address_mode,
    output page_cross, branch_taken,
    input  ir, t_state, sync, instr_done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction register and T-state sequencer around the opcode decoder.
// Define SEQ_RDY_EN to honour RDY; otherwise ready is ignored.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int T_W = 3
) (
  input logic              clk,
  input logic              rst,
  instr_sequencer_if.master bus
);
  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] EXEC  = 1'b1;

  localparam logic [1:0] EXT_NONE = 2'd0;
  localparam logic [1:0] EXT_T3   = 2'd1;
  localparam logic [1:0] EXT_T4   = 2'd2;
  localparam logic [1:0] EXT_BR   = 2'd3;

  localparam logic [T_W-1:0] T1   = T_W'(1);
  localparam logic [T_W-1:0] T2   = T_W'(2);
  localparam logic [T_W-1:0] T3   = T_W'(3);
  localparam logic [T_W-1:0] T4   = T_W'(4);
  localparam logic [T_W-1:0] TMAX = T_W'(6);

  logic [0:0]     state_q;
  logic [T_W-1:0] t_q;
  logic [7:0]     ir_q;
  logic [3:0]     len_q;
  logic [1:0]     kind_q;
  logic [1:0]     ext_q;

  logic       adv;
  logic       rmw;
  logic       store;
  logic [3:0] blen;
  logic [1:0] bkind;
  logic [3:0] len;
  logic [1:0] kind;
  logic       samp;
  logic [3:0] eff;
  logic       done;

`ifdef SEQ_RDY_EN
  assign adv = bus.ready;
`else
  logic ready_unused;
  assign ready_unused = bus.ready;
  assign adv = 1'b1;
`endif

  assign rmw = (bus.cmd inside {CMD_ASL, CMD_ROL, CMD_LSR,
                                CMD_ROR, CMD_INC, CMD_DEC})
             && !(bus.address_mode inside {AM_ACC, AM_IMPL});

  assign store = bus.cmd inside {CMD_STA, CMD_STX, CMD_STY};

  // Base length and extension kind from the decoder outputs
  always_comb begin
    blen  = 4'd2;
    bkind = EXT_NONE;
    unique case (1'b1)
      bus.cmd == CMD_BRK: blen = 4'd7;
      bus.cmd inside {CMD_RTS, CMD_RTI, CMD_JSR}: blen = 4'd6;
      bus.cmd inside {CMD_PLA, CMD_PLP}: blen = 4'd4;
      bus.cmd inside {CMD_PHA, CMD_PHP}: blen = 4'd3;
      bus.cmd == CMD_JMP:
        blen = (ir_q == 8'h6C) ? 4'd5 : 4'd3;
      default: begin
        case (bus.address_mode)
          AM_ZPG: blen = rmw ? 4'd5 : 4'd3;
          AM_ZPGX, AM_ZPGY, AM_ABS:
            blen = rmw ? 4'd6 : 4'd4;
          AM_ABSX, AM_ABSY: begin
            if (rmw) begin
              blen = 4'd7;
            end else if (store) begin
              blen = 4'd5;
            end else begin
              blen  = 4'd4;
              bkind = EXT_T3;
            end
          end
          AM_XIND: blen = 4'd6;
          AM_INDY: begin
            if (store) begin
              blen = 4'd6;
            end else begin
              blen  = 4'd5;
              bkind = EXT_T4;
            end
          end
          AM_REL: begin
            blen  = 4'd2;
            bkind = EXT_BR;
          end
          default: blen = 4'd2;
        endcase
      end
    endcase
  end

  // Last-cycle decision, using same-cycle samples at sample points
  always_comb begin
    len  = (t_q == T1) ? blen : len_q;
    kind = (t_q == T1) ? bkind : kind_q;
    samp = 1'b0;
    unique case (1'b1)
      kind == EXT_T3 && t_q == T3: samp = bus.page_cross;
      kind == EXT_T4 && t_q == T4: samp = bus.page_cross;
      kind == EXT_BR && t_q == T1: samp = bus.branch_taken;
      kind == EXT_BR && t_q == T2 && ext_q != 2'd0:
        samp = bus.page_cross;
      default: samp = 1'b0;
    endcase
    eff  = len + {2'b00, ext_q} + {3'b000, samp};
    done = (state_q == EXEC)
        && ((4'(t_q) + 4'd1 == eff) || (t_q == TMAX));
  end

  // FETCH/EXEC sequencing, opcode capture and length latching
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      t_q     <= '0;
      ir_q    <= 8'hEA;
      len_q   <= 4'd2;
      kind_q  <= EXT_NONE;
      ext_q   <= 2'd0;
    end else if (adv) begin
      unique case (state_q)
        FETCH: begin
          ir_q    <= bus.data_in;
          t_q     <= T1;
          state_q <= EXEC;
          ext_q   <= 2'd0;
        end
        EXEC: begin
          if (t_q == T1) begin
            len_q  <= blen;
            kind_q <= bkind;
          end
          ext_q <= ext_q + {1'b0, samp};
          if (done) begin
            t_q     <= '0;
            state_q <= FETCH;
          end else begin
            t_q <= t_q + T_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.ir         = ir_q;
  assign bus.t_state    = t_q;
  assign bus.sync       = (t_q == '0);
  assign bus.instr_done = done;
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a per-cycle expected-output
// queue filled by the stimulus and drained by an independent monitor.
module tb_instr_sequencer;
  import seq_pkg::*;

`ifdef SEQ_RDY_EN
  localparam bit RDY_EN = 1'b1;
`else
  localparam bit RDY_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0] t;
    logic       sync;
    logic       done;
    logic [7:0] ir;
  } exp_t;

  typedef struct {
    logic [7:0] op;
    logic [5:0] c;
    logic [3:0] m;
  } ent_t;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;
  logic [7:0] prev_ir;
  exp_t q[$];
  ent_t tbl[$];

  instr_sequencer_if #(.T_W(3)) bus();

  instr_sequencer #(.T_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction length straight from the opcode-timing rules
  function automatic int ref_len(input logic [7:0] op,
                                 input logic [5:0] c,
                                 input logic [3:0] m,
                                 input bit pc2, input bit pc3,
                                 input bit pc4, input bit bt1);
    bit rmw;
    bit st;
    int n;
    rmw = (c inside {CMD_ASL, CMD_LSR, CMD_ROL, CMD_ROR,
                     CMD_INC, CMD_DEC})
        && !(m inside {AM_ACC, AM_IMPL});
    st = c inside {CMD_STA, CMD_STX, CMD_STY};
    if (c == CMD_BRK) n = 7;
    else if (c inside {CMD_RTS, CMD_RTI, CMD_JSR}) n = 6;
    else if (c inside {CMD_PLA, CMD_PLP}) n = 4;
    else if (c inside {CMD_PHA, CMD_PHP}) n = 3;
    else if (c == CMD_JMP) n = (op == 8'h6C) ? 5 : 3;
    else begin
      case (m)
        AM_IMPL, AM_ACC, AM_IMM: n = 2;
        AM_ZPG: n = rmw ? 5 : 3;
        AM_ZPGX, AM_ZPGY, AM_ABS: n = rmw ? 6 : 4;
        AM_ABSX, AM_ABSY:
          n = rmw ? 7 : (st ? 5 : 4 + int'(pc3));
        AM_XIND: n = 6;
        AM_INDY: n = st ? 6 : 5 + int'(pc4);
        AM_REL: n = !bt1 ? 2 : (pc2 ? 4 : 3);
        default: n = 2;
      endcase
    end
    return (n > 7) ? 7 : n;
  endfunction

  task automatic run_instr(input logic [7:0] op,
                           input logic [5:0] c,
                           input logic [3:0] m,
                           input int pcf, input int btf,
                           input int stall_at, input int stall_n,
                           input int abort_at, input bit rnd);
    bit   pc[7];
    bit   bt[7];
    int   len;
    int   k;
    int   ns;
    int   ab;
    bit   r;
    bit   abort;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      pc[i] = (pcf < 0) ? 1'($urandom) : (pcf != 0);
      bt[i] = (btf < 0) ? 1'($urandom) : (btf != 0);
    end
    len = ref_len(op, c, m, pc[2], pc[3], pc[4], bt[1]);
    ab = (abort_at == -2) ? int'($urandom_range(1, len - 1))
                          : abort_at;
    k  = 0;
    ns = 0;
    while (k < len) begin
      r = 1'b1;
      if (rnd && ($urandom % 4 == 0)) r = 1'b0;
      if (k == stall_at && ns < stall_n) begin
        r = 1'b0;
        ns++;
      end
      abort = (k == ab);
      if (abort) r = 1'b0;
      bus.ready = r;
      if (!RDY_EN) r = 1'b1;
      bus.data_in = (k == 0 && r) ? op : 8'($urandom);
      bus.cmd = (k > 0) ? c : 6'($urandom);
      bus.address_mode = (k > 0) ? m : 4'($urandom);
      bus.page_cross = pc[k];
      bus.branch_taken = bt[k];
      rst = abort;
      e.t    = 3'(k);
      e.sync = (k == 0);
      e.done = (k == len - 1);
      e.ir   = (k == 0) ? prev_ir : op;
      q.push_back(e);
      @(posedge clk);
      #1;
      if (abort) begin
        rst = 1'b0;
        prev_ir = 8'hEA;
        return;
      end
      if (r) k++;
    end
    prev_ir = op;
  endtask

  // Monitor: compare every presented cycle against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      nvec++;
      if (bus.t_state !== e.t || bus.sync !== e.sync ||
          bus.instr_done !== e.done || bus.ir !== e.ir) begin
        nerr++;
        $display("FAIL cyc @%0t: got t=%0d sync=%b done=%b ir=%h, want t=%0d sync=%b done=%b ir=%h",
                 $time, bus.t_state, bus.sync, bus.instr_done,
                 bus.ir, e.t, e.sync, e.done, e.ir);
      end
    end
  end

  initial begin
    ent_t en;
    nvec = 0;
    nerr = 0;
    prev_ir = 8'hEA;
    tbl.push_back('{8'hAD, CMD_LDA, AM_ABS});
    tbl.push_back('{8'hBD, CMD_LDA, AM_ABSX});
    tbl.push_back('{8'hB9, CMD_LDA, AM_ABSY});
    tbl.push_back('{8'h7D, CMD_ADC, AM_ABSX});
    tbl.push_back('{8'h9D, CMD_STA, AM_ABSX});
    tbl.push_back('{8'h99, CMD_STA, AM_ABSY});
    tbl.push_back('{8'hB1, CMD_LDA, AM_INDY});
    tbl.push_back('{8'h71, CMD_ADC, AM_INDY});
    tbl.push_back('{8'h91, CMD_STA, AM_INDY});
    tbl.push_back('{8'hA1, CMD_LDA, AM_XIND});
    tbl.push_back('{8'hA5, CMD_LDA, AM_ZPG});
    tbl.push_back('{8'hB5, CMD_LDA, AM_ZPGX});
    tbl.push_back('{8'hB6, CMD_LDX, AM_ZPGY});
    tbl.push_back('{8'hA9, CMD_LDA, AM_IMM});
    tbl.push_back('{8'hEA, CMD_NOP, AM_IMPL});
    tbl.push_back('{8'hE8, CMD_INX, AM_IMPL});
    tbl.push_back('{8'h0A, CMD_ASL, AM_ACC});
    tbl.push_back('{8'hE6, CMD_INC, AM_ZPG});
    tbl.push_back('{8'hF6, CMD_INC, AM_ZPGX});
    tbl.push_back('{8'hEE, CMD_INC, AM_ABS});
    tbl.push_back('{8'hFE, CMD_INC, AM_ABSX});
    tbl.push_back('{8'h1E, CMD_ASL, AM_ABSX});
    tbl.push_back('{8'h8D, CMD_STA, AM_ABS});
    tbl.push_back('{8'h85, CMD_STA, AM_ZPG});
    tbl.push_back('{8'h48, CMD_PHA, AM_IMPL});
    tbl.push_back('{8'h08, CMD_PHP, AM_IMPL});
    tbl.push_back('{8'h68, CMD_PLA, AM_IMPL});
    tbl.push_back('{8'h28, CMD_PLP, AM_IMPL});
    tbl.push_back('{8'h60, CMD_RTS, AM_IMPL});
    tbl.push_back('{8'h40, CMD_RTI, AM_IMPL});
    tbl.push_back('{8'h20, CMD_JSR, AM_ABS});
    tbl.push_back('{8'h00, CMD_BRK, AM_IMPL});
    tbl.push_back('{8'h4C, CMD_JMP, AM_ABS});
    tbl.push_back('{8'h6C, CMD_JMP, AM_ABS});
    tbl.push_back('{8'hD0, CMD_BNE, AM_REL});
    tbl.push_back('{8'hF0, CMD_BEQ, AM_REL});
    tbl.push_back('{8'hFF, CMD_LDA, 4'hF});

    rst = 1'b1;
    bus.ready = 1'b1;
    bus.data_in = 8'h00;
    bus.cmd = CMD_NOP;
    bus.address_mode = AM_IMPL;
    bus.page_cross = 1'b0;
    bus.branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(8'hAD, CMD_LDA, AM_ABS, 0, 0, -1, 0, -1, 1'b0);
    run_instr(8'hBD, CMD_LDA, AM_ABSX, 1, 0, -1, 0, -1, 1'b0);
    run_instr(8'hBD, CMD_LDA, AM_ABSX, 0, 0, -1, 0, -1, 1'b0);
    run_instr(8'h9D, CMD_STA, AM_ABSX, 1, 0, -1, 0, -1, 1'b0);
    run_instr(8'h9D, CMD_STA, AM_ABSX, 0, 0, -1, 0, -1, 1'b0);
    run_instr(8'hB1, CMD_LDA, AM_INDY, 1, 0, -1, 0, -1, 1'b0);
    run_instr(8'hD0, CMD_BNE, AM_REL, 1, 0, -1, 0, -1, 1'b0);
    run_instr(8'hD0, CMD_BNE, AM_REL, 0, 1, -1, 0, -1, 1'b0);
    run_instr(8'hD0, CMD_BNE, AM_REL, 1, 1, -1, 0, -1, 1'b0);
    run_instr(8'hE6, CMD_INC, AM_ZPG, 0, 0, 2, 3, -1, 1'b0);
    run_instr(8'h6C, CMD_JMP, AM_ABS, 0, 0, -1, 0, -1, 1'b0);
    run_instr(8'h00, CMD_BRK, AM_IMPL, 1, 1, -1, 0, -1, 1'b0);
    run_instr(8'h00, CMD_BRK, AM_IMPL, 0, 0, -1, 0, 4, 1'b0);
    run_instr(8'hFF, CMD_LDA, 4'hF, 1, 1, -1, 0, -1, 1'b0);
    run_instr(8'hAD, CMD_LDA, AM_ABS, 0, 0, -1, 0, -1, 1'b0);

    for (int n = 0; n < 300; n++) begin
      en = tbl[$urandom_range(0, tbl.size() - 1)];
      run_instr(en.op, en.c, en.m, -1, -1, -1, 0,
                ($urandom % 25 == 0) ? -2 : -1, 1'b1);
    end

    repeat (2) @(negedge clk);
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
